// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage instruction fields, FLUSH, and the forwarding/stall results of fwd_hazard_ctrl.
// The master side drives ID_* and FLUSH; the slave side (the controller) returns FWD_A/FWD_B/STALL.
interface fwd_hazard_ctrl_if #(
    parameter int unsigned RA_W = 5
);
    logic [RA_W-1:0] ID_RS1;
    logic [RA_W-1:0] ID_RS2;
    logic            ID_USE1;
    logic            ID_USE2;
    logic [RA_W-1:0] ID_RD;
    logic            ID_REGWRITE;
    logic            ID_MEMREAD;
    logic            FLUSH;
    logic [1:0]      FWD_A;
    logic [1:0]      FWD_B;
    logic            STALL;

    modport master (
        output ID_RS1,
        output ID_RS2,
        output ID_USE1,
        output ID_USE2,
        output ID_RD,
        output ID_REGWRITE,
        output ID_MEMREAD,
        output FLUSH,
        input  FWD_A,
        input  FWD_B,
        input  STALL
    );

    modport slave (
        input  ID_RS1,
        input  ID_RS2,
        input  ID_USE1,
        input  ID_USE2,
        input  ID_RD,
        input  ID_REGWRITE,
        input  ID_MEMREAD,
        input  FLUSH,
        output FWD_A,
        output FWD_B,
        output STALL
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select and load-use stall generator with a shadow ID/EX-EX/MEM-MEM/WB pipe.
// Optional FWD_HAZARD_PERF_EN adds free-running STALL_CNT / FLUSH_CNT event counters.
module fwd_hazard_ctrl #(
    parameter int unsigned RA_W     = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    fwd_hazard_ctrl_if.slave     bus
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]          STALL_CNT,
    output logic [31:0]          FLUSH_CNT
`endif
);

    localparam logic ZeroEn = (ZERO_REG != 0);

    typedef struct packed {
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic            use1;
        logic            use2;
        logic [RA_W-1:0] rd;
        logic            regwrite;
        logic            memread;
    } idex_t;

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic            regwrite;
        logic            memread;
    } exmem_t;

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic            regwrite;
    } memwb_t;

    idex_t  idex_q,  idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;

    logic stall;

    function automatic logic src_match(input logic [RA_W-1:0] rd,
                                       input logic            regwrite,
                                       input logic [RA_W-1:0] rs,
                                       input logic            use_rs);
        return use_rs && regwrite && (rd == rs) && !(ZeroEn && (rs == '0));
    endfunction

    // Load in EX whose result the ID instruction needs: hold ID for one cycle.
    always_comb begin
        stall = 1'b0;
        if (idex_q.memread && idex_q.regwrite && !(ZeroEn && (idex_q.rd == '0))) begin
            stall = (bus.ID_USE1 && (bus.ID_RS1 == idex_q.rd)) ||
                    (bus.ID_USE2 && (bus.ID_RS2 == idex_q.rd));
        end
    end

    always_comb begin
        idex_d = '0;
        if (!(bus.FLUSH || stall)) begin
            idex_d.rs1      = bus.ID_RS1;
            idex_d.rs2      = bus.ID_RS2;
            idex_d.use1     = bus.ID_USE1;
            idex_d.use2     = bus.ID_USE2;
            idex_d.rd       = bus.ID_RD;
            idex_d.regwrite = bus.ID_REGWRITE;
            idex_d.memread  = bus.ID_MEMREAD;
        end
        exmem_d.rd       = idex_q.rd;
        exmem_d.regwrite = idex_q.regwrite;
        exmem_d.memread  = idex_q.memread;
        memwb_d.rd       = exmem_q.rd;
        memwb_d.regwrite = exmem_q.regwrite;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    // EX/MEM is checked first since it carries the younger result.
    always_comb begin
        bus.FWD_A = 2'b00;
        bus.FWD_B = 2'b00;
        if (src_match(exmem_q.rd, exmem_q.regwrite, idex_q.rs1, idex_q.use1)) begin
            bus.FWD_A = 2'b10;
        end else if (src_match(memwb_q.rd, memwb_q.regwrite, idex_q.rs1, idex_q.use1)) begin
            bus.FWD_A = 2'b01;
        end
        if (src_match(exmem_q.rd, exmem_q.regwrite, idex_q.rs2, idex_q.use2)) begin
            bus.FWD_B = 2'b10;
        end else if (src_match(memwb_q.rd, memwb_q.regwrite, idex_q.rs2, idex_q.use2)) begin
            bus.FWD_B = 2'b01;
        end
        bus.STALL = stall;
    end

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (bus.FLUSH) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;
    assign FLUSH_CNT = flush_cnt_q;
`endif

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control block that generates the 2-bit select codes consumed by the forwardA/forwardB 3-input muxes in the EX stage, plus the load-use stall signal.
- Keeps its own shadow pipeline of register-destination information across the ID/EX, EX/MEM and MEM/WB stages.
- Compares EX-stage sources against older in-flight destinations.
- Sits beside the datapath pipeline registers and drives PC/IF-ID write-enables through STALL.

Parameters:
- RA_W, 5, register address width.
- ZERO_REG, 1, if 1 then register address 0 is never a forwarding or stall source.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RSTn  input  1  synchronous active-low reset, sampled on the rising edge of CLK.
- ID_RS1  input  RA_W  source 1 address of the instruction in ID.
- ID_RS2  input  RA_W  source 2 address of the instruction in ID.
- ID_USE1  input  1  ID instruction reads RS1.
- ID_USE2  input  1  ID instruction reads RS2.
- ID_RD  input  RA_W  destination of the ID instruction.
- ID_REGWRITE  input  1  ID instruction writes RD.
- ID_MEMREAD  input  1  ID instruction is a load.
- FLUSH  input  1  taken branch/jump resolved in EX; squash the instruction entering EX.
- FWD_A  output  2  select for the forwardA mux: 00 register file, 01 MEM/WB result, 10 EX/MEM result.
- FWD_B  output  2  select for the forwardB mux; same encoding as FWD_A.
- STALL  output  1  1 = hold PC and the IF/ID register; the datapath deasserts their write enables.

Behaviour:
- State: three stage records (IDEX, EXMEM, MEMWB).
  - Each record holds rd and regwrite.
  - IDEX and EXMEM also hold memread.
  - IDEX also holds rs1, rs2, use1 and use2.
- Reset: on a rising edge with RSTn=0, every record field is cleared, giving bubbles. FWD_A=FWD_B=00 and STALL=0 from then until new instructions arrive. Reset mid-operation discards all in-flight entries with no residual forwarding.
- Bubble: all fields zero.
- Each rising edge with RSTn=1:
  - MEMWB <= EXMEM.
  - EXMEM <= IDEX.
  - IDEX <= bubble if (FLUSH | STALL), else the ID_* inputs.
  - FLUSH and STALL in the same cycle produce a single bubble; FLUSH has no additional effect.
- Match condition m(stage, rs, use): use & stage.regwrite & (stage.rd==rs) & !(ZERO_REG & rs==0).
- FWD_A, combinational from registered state:
  - 10 if m(EXMEM, IDEX.rs1, IDEX.use1).
  - else 01 if m(MEMWB, IDEX.rs1, IDEX.use1).
  - else 00.
  - EX/MEM has priority because it holds the newer value.
- FWD_B: same rule using rs2/use2.
- STALL, combinational: IDEX.memread & IDEX.regwrite & !(ZERO_REG & IDEX.rd==0) & ((ID_USE1 & ID_RS1==IDEX.rd) | (ID_USE2 & ID_RS2==IDEX.rd)).
  - Lasts exactly one cycle per load-use pair: the load advances to EXMEM and a bubble enters IDEX.
  - On the following cycle the consumer is in EX with the load in MEMWB, so FWD=01.
- No WB-to-ID forwarding: the register file writes on the falling CLK edge, so same-cycle ID reads already see the WB value.
- FLUSH has no effect on EXMEM or MEMWB, because older instructions complete.
- Outputs depend only on state plus ID_* inputs; there is no combinational path from FLUSH to any output.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- Defined:
  - Adds output STALL_CNT (32 bits) and output FLUSH_CNT (32 bits).
  - STALL_CNT increments on each rising edge where STALL=1 and RSTn=1.
  - FLUSH_CNT increments on each rising edge where FLUSH=1 and RSTn=1.
  - Both counters clear on reset and wrap from 0xFFFFFFFF to 0.
- Undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Back-to-back dependency: add x5 (rd=5, regwrite) then sub using rs1=5. The cycle the sub is in EX -> FWD_A=10, FWD_B=00, STALL=0.
- Distance-2 dependency: rd=7 writer, one independent instruction, then consumer with rs2=7. The cycle the consumer is in EX -> FWD_B=01.
- Both stages match: EXMEM.rd=3 and MEMWB.rd=3, consumer rs1=3 -> FWD_A=10 (priority to the newer value).
- Load-use: load rd=9 in IDEX, ID instruction uses rs1=9 -> STALL=1 for exactly 1 cycle. Next cycle STALL=0 with consumer FWD_A=01. With the macro enabled, STALL_CNT=1.
- x0 and unused sources: writer rd=0, consumer rs1=0 -> FWD_A=00. Load rd=4 with ID_USE2=0 and ID_RS2=4 -> STALL=0.
- FLUSH and reset: FLUSH=1 with a rd=6 writer in ID; next instruction reads rs1=6 -> FWD_A=00. Then pulse RSTn=0 for 1 cycle with writers in flight -> FWD_A=FWD_B=00 and STALL=0 the cycle after.
